// File: rtl/spike_rate_decoder_if.sv
// Bundle between the spike source/controller and the rate decoder.
// The master drives enable, spikes and window length; the decoder returns rate and ISI results.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
);
  logic             en;
  logic             spike_in;
  logic [WIN_W-1:0] window_len;
  logic [CNT_W-1:0] rate_out;
  logic             rate_valid;
  logic             rate_sat;
  logic [WIN_W-1:0] isi_out;
  logic             isi_valid;

  modport master (
    output en, spike_in, window_len,
    input  rate_out, rate_valid, rate_sat, isi_out, isi_valid
  );

  modport slave (
    input  en, spike_in, window_len,
    output rate_out, rate_valid, rate_sat, isi_out, isi_valid
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Converts a one-bit spike train into a windowed, saturating spike count
// and tracks the most recent inter-spike interval.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | en low: counters cleared, ISI tracker disarmed, outputs held
// ST_RUN  | en high: counting spikes in back-to-back windows, tracking ISI
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  spike_rate_decoder_if.slave bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic             win_start;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic             sat;
  logic [WIN_W-1:0] gap;
  logic             armed;

  logic [CNT_W-1:0] rate_q;
  logic             rate_sat_q;
  logic             rate_valid_q;
  logic [WIN_W-1:0] isi_q;
  logic             isi_valid_q;

  logic [WIN_W-1:0] win_cur;
  logic             win_end;
  logic [CNT_W-1:0] cnt_nxt;
  logic             sat_nxt;

  // The down-counter holds cycles remaining minus one; window_len-1 wraps 0 to the full 2^WIN_W length.
  always_comb begin
    win_cur = win_cnt;
    if (state == ST_IDLE || win_start) win_cur = bus.window_len - 1'b1;
    win_end = (win_cur == '0);
    cnt_nxt = spk_cnt;
    if (bus.spike_in && spk_cnt != '1) cnt_nxt = spk_cnt + 1'b1;
    sat_nxt = sat | (cnt_nxt == '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      win_start    <= 1'b0;
      win_cnt      <= '0;
      spk_cnt      <= '0;
      sat          <= 1'b0;
      gap          <= '0;
      armed        <= 1'b0;
      rate_q       <= '0;
      rate_sat_q   <= 1'b0;
      rate_valid_q <= 1'b0;
      isi_q        <= '0;
      isi_valid_q  <= 1'b0;
    end else begin
      rate_valid_q <= 1'b0;
      isi_valid_q  <= 1'b0;
      if (!bus.en) begin
        state     <= ST_IDLE;
        win_start <= 1'b0;
        win_cnt   <= '0;
        spk_cnt   <= '0;
        sat       <= 1'b0;
        gap       <= '0;
        armed     <= 1'b0;
      end else begin
        state <= ST_RUN;
        if (win_end) begin
          rate_q       <= cnt_nxt;
          rate_sat_q   <= sat_nxt;
          rate_valid_q <= 1'b1;
          spk_cnt      <= '0;
          sat          <= 1'b0;
          win_start    <= 1'b1;
          win_cnt      <= '0;
        end else begin
          spk_cnt   <= cnt_nxt;
          sat       <= sat_nxt;
          win_start <= 1'b0;
          win_cnt   <= win_cur - 1'b1;
        end
        // gap counts cycles since the last spike; the first spike only arms the tracker
        if (bus.spike_in) begin
          gap   <= WIN_W'(1);
          armed <= 1'b1;
          if (armed) begin
            isi_q       <= gap;
            isi_valid_q <= 1'b1;
          end
        end else if (gap != '1) begin
          gap <= gap + 1'b1;
        end
      end
    end
  end

  assign bus.rate_out   = rate_q;
  assign bus.rate_sat   = rate_sat_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.isi_out    = isi_q;
  assign bus.isi_valid  = isi_valid_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder: vector table, directed corner
// sequences and random stimulus against a behavioural window/ISI model.
module tb_spike_rate_decoder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clk_on = 1'b0;

  spike_rate_decoder_if #(.CNT_W(8), .WIN_W(8)) bus ();

  spike_rate_decoder #(.CNT_W(8), .WIN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always begin
    #5;
    if (clk_on) clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: window position / spike tally in plain integers, ISI from spike timestamps.
  int   m_t, m_pos, m_len, m_cnt, m_last;
  int   m_rate, m_isi;
  logic m_sat, m_rv, m_iv;

  typedef struct {
    logic       en;
    logic       spike;
    logic [7:0] wl;
    logic       rv;
    logic [7:0] rate;
    logic       sat;
    logic       iv;
    logic [7:0] isi;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mkv(input logic e, input logic s, input int wl, input logic rv,
                               input int rate, input logic sat, input logic iv, input int isi);
    vec_t v;
    v.en = e; v.spike = s; v.wl = wl[7:0]; v.rv = rv;
    v.rate = rate[7:0]; v.sat = sat; v.iv = iv; v.isi = isi[7:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_pos = 0; m_len = 1; m_cnt = 0; m_last = -1;
    m_rate = 0; m_isi = 0; m_sat = 1'b0; m_rv = 1'b0; m_iv = 1'b0;
  endtask

  task automatic model_edge(input logic e, input logic s, input logic [7:0] wl);
    m_rv = 1'b0;
    m_iv = 1'b0;
    if (!e) begin
      m_pos = 0; m_cnt = 0; m_last = -1;
    end else begin
      if (m_pos == 0) m_len = (wl == 8'd0) ? 256 : int'(wl);
      if (s) begin
        m_cnt++;
        if (m_last >= 0) begin
          m_isi = (m_t - m_last > 255) ? 255 : m_t - m_last;
          m_iv  = 1'b1;
        end
        m_last = m_t;
      end
      m_pos++;
      if (m_pos == m_len) begin
        m_rate = (m_cnt > 255) ? 255 : m_cnt;
        m_sat  = (m_cnt >= 255);
        m_rv   = 1'b1;
        m_cnt  = 0;
        m_pos  = 0;
      end
    end
    m_t++;
  endtask

  task automatic check_model();
    check("rate_valid", 32'(bus.rate_valid), 32'(m_rv));
    check("rate_out",   32'(bus.rate_out),   32'(m_rate));
    check("rate_sat",   32'(bus.rate_sat),   32'(m_sat));
    check("isi_valid",  32'(bus.isi_valid),  32'(m_iv));
    check("isi_out",    32'(bus.isi_out),    32'(m_isi));
  endtask

  // Called just after a falling edge: drive inputs, let the rising edge take them, check at the next fall.
  task automatic step(input logic e, input logic s, input logic [7:0] wl);
    bus.en = e;
    bus.spike_in = s;
    bus.window_len = wl;
    @(posedge clk);
    model_edge(e, s, wl);
    @(negedge clk);
    check_model();
  endtask

  initial begin
    int pulses;
    int saved;
    logic r_en;
    logic [7:0] r_wl;

    tbl[0]  = mkv(1, 1, 4, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 4, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(1, 1, 4, 0, 0, 0, 1, 2);
    tbl[3]  = mkv(1, 1, 4, 1, 3, 0, 1, 1);
    tbl[4]  = mkv(1, 0, 4, 0, 3, 0, 0, 1);
    tbl[5]  = mkv(1, 1, 4, 0, 3, 0, 1, 2);
    tbl[6]  = mkv(1, 0, 4, 0, 3, 0, 0, 2);
    tbl[7]  = mkv(0, 1, 4, 0, 3, 0, 0, 2);
    tbl[8]  = mkv(1, 1, 1, 1, 1, 0, 0, 2);
    tbl[9]  = mkv(1, 0, 1, 1, 0, 0, 0, 2);
    tbl[10] = mkv(1, 1, 1, 1, 1, 0, 1, 2);
    tbl[11] = mkv(1, 1, 1, 1, 1, 0, 1, 1);
    tbl[12] = mkv(0, 0, 1, 0, 1, 0, 0, 1);

    bus.en = 1'b0;
    bus.spike_in = 1'b0;
    bus.window_len = 8'd0;
    model_reset();

    // Asynchronous reset with the clock stopped
    #3 rst = 1'b1;
    #2;
    check("rst_rate_out",   32'(bus.rate_out),   32'd0);
    check("rst_rate_valid", 32'(bus.rate_valid), 32'd0);
    check("rst_rate_sat",   32'(bus.rate_sat),   32'd0);
    check("rst_isi_out",    32'(bus.isi_out),    32'd0);
    check("rst_isi_valid",  32'(bus.isi_valid),  32'd0);
    clk_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Table: window_len=4 with en dropped on window cycle 3, then window_len=1
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].spike, tbl[i].wl);
      check($sformatf("tbl%0d_rv", i),   32'(bus.rate_valid), 32'(tbl[i].rv));
      check($sformatf("tbl%0d_rate", i), 32'(bus.rate_out),   32'(tbl[i].rate));
      check($sformatf("tbl%0d_sat", i),  32'(bus.rate_sat),   32'(tbl[i].sat));
      check($sformatf("tbl%0d_iv", i),   32'(bus.isi_valid),  32'(tbl[i].iv));
      check($sformatf("tbl%0d_isi", i),  32'(bus.isi_out),    32'(tbl[i].isi));
    end

    // Dense train, window_len=10
    step(0, 0, 10);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      step(1, 1, 10);
      if (bus.rate_valid) pulses++;
      if (c > 0) check("dense_isi_valid", 32'(bus.isi_valid), 32'd1);
    end
    check("dense_pulses", 32'(pulses), 32'd3);
    check("dense_rate", 32'(bus.rate_out), 32'd10);
    check("dense_isi", 32'(bus.isi_out), 32'd1);

    // Sparse train: spikes at window cycles 2, 7, 15
    step(0, 0, 16);
    for (int c = 0; c < 16; c++) begin
      step(1, (c == 2 || c == 7 || c == 15), 16);
      if (c == 2) check("sparse_first_arm", 32'(bus.isi_valid), 32'd0);
      if (c == 7) check("sparse_isi5", 32'(bus.isi_out), 32'd5);
    end
    check("sparse_isi8", 32'(bus.isi_out), 32'd8);
    check("sparse_rv", 32'(bus.rate_valid), 32'd1);
    check("sparse_rate", 32'(bus.rate_out), 32'd3);

    // ISI saturation over a long gap
    step(0, 0, 0);
    step(1, 1, 0);
    for (int c = 0; c < 300; c++) step(1, 0, 0);
    step(1, 1, 0);
    check("isi_saturate", 32'(bus.isi_out), 32'd255);

    // Counter saturation, window_len=0 means 256
    step(0, 0, 0);
    for (int c = 0; c < 256; c++) step(1, 1, 0);
    check("sat_rate", 32'(bus.rate_out), 32'd255);
    check("sat_flag", 32'(bus.rate_sat), 32'd1);
    for (int c = 0; c < 256; c++) step(1, 0, 0);
    check("unsat_rate", 32'(bus.rate_out), 32'd0);
    check("unsat_flag", 32'(bus.rate_sat), 32'd0);

    // Abort at cycle 15 of a 20-cycle window
    step(0, 0, 20);
    saved = m_rate;
    for (int c = 0; c < 15; c++) step(1, (c < 12), 20);
    step(0, 1, 20);
    check("abort_rv", 32'(bus.rate_valid), 32'd0);
    check("abort_rate_held", 32'(bus.rate_out), 32'(saved));

    // window_len changed mid-window, then re-enable with the new length
    for (int c = 0; c < 7; c++) step(1, 1, 20);
    for (int c = 0; c < 4; c++) step(1, 1, 5);
    check("midchange_no_rv", 32'(bus.rate_valid), 32'd0);
    step(0, 0, 5);
    step(1, 1, 5);
    step(1, 0, 5);
    step(1, 1, 5);
    step(1, 1, 5);
    check("reload_no_rv_early", 32'(bus.rate_valid), 32'd0);
    step(1, 0, 5);
    check("reload_rv", 32'(bus.rate_valid), 32'd1);
    check("reload_rate", 32'(bus.rate_out), 32'd3);

    // Asynchronous reset mid-window
    for (int c = 0; c < 6; c++) step(1, 1, 3);
    #2 rst = 1'b1;
    #1;
    check("midrst_rate_out", 32'(bus.rate_out), 32'd0);
    check("midrst_isi_out",  32'(bus.isi_out),  32'd0);
    check("midrst_sat",      32'(bus.rate_sat), 32'd0);
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 1, 3);
    step(1, 1, 3);
    step(1, 0, 3);
    check("postrst_rate", 32'(bus.rate_out), 32'd2);

    // Random traffic against the model
    r_en = 1'b1;
    r_wl = 8'd5;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 4) r_en = ~r_en;
      if ($urandom_range(0, 99) < 5) r_wl = 8'($urandom_range(0, 12));
      step(r_en, ($urandom_range(0, 2) == 0), r_wl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
